// File: rtl/cpu_defs.sv
// Shared CPU constants and types: boot vector, exception codes, fetch entry layout.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [4:0]  EXC_ADEL         = 5'h04;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry output buffer between instruction fetch and the IF/ID register.
module fetch_buf
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  input  logic        load_adel,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        adel
);

  fetch_entry_t entry;

  // Clear beats load, and load beats drain, so a drained slot can refill in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)      valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (drain) valid <= 1'b0;
  end

  // NOTE: the payload has no reset; it is only observed while valid=1.
  always_ff @(posedge clk) begin
    if (load && !clear) entry <= '{pc: load_pc, inst: load_inst, adel: load_adel};
  end

  assign pc   = entry.pc;
  assign inst = entry.inst;
  assign adel = entry.adel;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding SRAM request control, redirect/cancel handling,
// and misaligned-PC (ADEL) detection feeding a one-entry output buffer.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        allow_out,
  output logic        valid_out,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        outstanding;
  logic        cancel;
  logic        buf_valid;

  logic        drain;
  logic        buf_free;
  logic        misaligned;
  logic        accept;
  logic        take_data;
  logic        take_adel;
  logic        buf_load;
  logic [31:0] load_pc;
  logic [31:0] load_inst;
  logic        load_adel;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    drain         = buf_valid && allow_out;
    buf_free      = !buf_valid || drain;
    misaligned    = !is_aligned(fetch_pc);
    inst_sram_req = !reset && !redirect && !outstanding && !cancel && buf_free && !misaligned;
    accept        = inst_sram_req && inst_sram_addr_ok;
    // Redirect discards both the returning word and a pending ADEL entry.
    take_data     = inst_sram_data_ok && outstanding && !cancel && !redirect;
    take_adel     = misaligned && !outstanding && buf_free && !redirect;
    buf_load      = take_data || take_adel;
    load_pc       = fetch_pc;
    load_inst     = '0;
    load_adel     = 1'b1;
    if (take_data) begin
      load_pc   = req_pc;
      load_inst = inst_sram_rdata;
      load_adel = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      cancel      <= 1'b0;
    end else begin
      if (redirect)    fetch_pc <= redirect_pc;
      else if (accept) fetch_pc <= fetch_pc + PC_STEP;

      if (accept)                 outstanding <= 1'b1;
      else if (inst_sram_data_ok) outstanding <= 1'b0;

      // A response always retires the cancel; a coincident redirect leaves nothing to cancel.
      if (inst_sram_data_ok)                    cancel <= 1'b0;
      else if (redirect && (outstanding || accept)) cancel <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_pc <= fetch_pc;
  end

  fetch_buf u_fetch_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .drain     (drain),
    .clear     (redirect),
    .load_pc   (load_pc),
    .load_inst (load_inst),
    .load_adel (load_adel),
    .valid     (buf_valid),
    .pc        (out_pc),
    .inst      (out_inst),
    .adel      (out_adel)
  );

  assign valid_out      = buf_valid && !reset;
  assign inst_sram_addr = fetch_pc;

endmodule
